ntsc_capture: RTL and testbench

Capture front end that sits directly upstream of the memory interface. It takes synchronized decoded video pixels, crops them to one field of IMAGE_WIDTH × IMAGE_HEIGHT, and truncates each pixel to PIXEL_BITS. It packs two pixels per memory word and presents them through a small FIFO on the ntsc_flag / ntsc_pixel / done_ntsc handshake. It also produces the single-cycle frame_flag that rotates the frame buffers, issued only once all words of the previous frame have drained.

---
 rtl/ntsc_capture.sv | 197 +++++++++++++++++++
 tb/tb_ntsc_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_capture.sv
// ntsc_capture: crops one field of decoded video to IMAGE_WIDTH x IMAGE_HEIGHT,
// truncates pixels to 6:6:6, packs two pixels per memory word and queues the
// words in a small FIFO for the memory interface. A single-cycle frame_flag is
// issued once the previous frame's words have fully drained.
module ntsc_capture #(
  parameter int MEM_WIDTH    = 36,
  parameter int PIXEL_BITS   = 18,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 240,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vid_valid,
  input  logic [29:0]          vid_ycrcb,
  input  logic                 vid_field,
  input  logic                 vid_vblank,
  input  logic                 vid_hblank,
  output logic                 ntsc_flag,
  output logic [MEM_WIDTH-1:0] ntsc_pixel,
  input  logic                 done_ntsc,
  output logic                 frame_flag,
  output logic                 overflow
);

  localparam int XW = $clog2(IMAGE_WIDTH + 1);
  localparam int YW = $clog2(IMAGE_HEIGHT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XW-1:0] XLIM  = XW'(IMAGE_WIDTH);
  localparam logic [YW-1:0] YLIM  = YW'(IMAGE_HEIGHT);
  localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_SYNC,
    S_CAPTURE
  } state_t;

  state_t r_state, w_state_nxt;

  // Blanking history for edge detection
  logic r_vblank, r_hblank;
  logic w_frame_start, w_line_start, w_line_end;

  // Capture window position and pixel pairing
  logic [XW-1:0]         r_x, w_x_eff;
  logic [YW-1:0]         r_y, w_y_eff;
  logic                  r_line_seen;
  logic [PIXEL_BITS-1:0] r_half;
  logic                  r_half_vld;
  logic [PIXEL_BITS-1:0] w_pix;

  logic w_cap, w_ls0, w_accept;
  logic w_push_pair, w_push_pad, w_push;
  logic [MEM_WIDTH-1:0] w_push_data;
  logic w_frame_flag;

  // FIFO storage and pointers
  logic [MEM_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rd, r_wr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 w_pop, w_full, w_wr_en, w_empty;

  // Chroma/luma LSBs are discarded by the 6:6:6 truncation
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, vid_ycrcb[23:20], vid_ycrcb[13:10], vid_ycrcb[3:0]};

  assign w_pix = {vid_ycrcb[29:24], vid_ycrcb[19:14], vid_ycrcb[9:4]};

  // Edges are taken against last cycle's blanking bits
  assign w_frame_start = r_vblank & ~vid_vblank & ~vid_field;
  assign w_line_start  = r_hblank & ~vid_hblank;
  assign w_line_end    = ~r_hblank & vid_hblank;

  // Register blanking bits for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vblank <= 1'b0;
      r_hblank <= 1'b0;
    end else begin
      r_vblank <= vid_vblank;
      r_hblank <= vid_hblank;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and frame_flag decode; SYNC only follows an empty FIFO
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_flag = 1'b0;
    case (r_state)
      S_IDLE:    if (w_frame_start) w_state_nxt = S_FLUSH;
      S_FLUSH:   if (w_empty) w_state_nxt = S_SYNC;
      S_SYNC: begin
        w_frame_flag = 1'b1;
        w_state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: if (w_frame_start) w_state_nxt = S_FLUSH;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Window bookkeeping: a line start in the same cycle as a pixel applies
  // first, so the first pixel of a line lands at x = 0 of the new y.
  // Field-1 lines never touch x/y and never contribute pixels.
  always_comb begin
    w_cap    = (r_state == S_CAPTURE) && !w_frame_start;
    w_ls0    = w_cap && w_line_start && !vid_field;
    w_x_eff  = w_ls0 ? '0 : r_x;
    w_y_eff  = (w_ls0 && r_line_seen && (r_y < YLIM)) ? r_y + YW'(1) : r_y;
    w_accept = w_cap && vid_valid && !vid_field &&
               (w_x_eff < XLIM) && (w_y_eff < YLIM);
    w_push_pair = w_accept && r_half_vld;
    w_push_pad  = w_cap && !w_accept && w_line_end && r_half_vld;
    w_push      = w_push_pair || w_push_pad;
    w_push_data = w_push_pair ? {r_half, w_pix} : {r_half, {PIXEL_BITS{1'b0}}};
  end

  // Capture position, line tracking and half-word pairing
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_seen <= 1'b0;
      r_half      <= '0;
      r_half_vld  <= 1'b0;
    end else if (r_state == S_SYNC) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_seen <= 1'b0;
      r_half      <= '0;
      r_half_vld  <= 1'b0;
    end else if (w_frame_start) begin
      // an unpaired pixel from the aborted frame is dropped
      r_half_vld <= 1'b0;
    end else if (w_cap) begin
      if (w_ls0) r_line_seen <= 1'b1;
      r_x <= w_x_eff + XW'(w_accept);
      r_y <= w_y_eff;
      if (w_accept) begin
        if (r_half_vld) begin
          r_half_vld <= 1'b0;
        end else begin
          r_half     <= w_pix;
          r_half_vld <= 1'b1;
        end
      end else if (w_push_pad) begin
        r_half_vld <= 1'b0;
      end
    end
  end

  // FIFO control: a push into a full FIFO is accepted when a pop frees the slot
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CFULL);
  assign w_pop   = done_ntsc && !w_empty;
  assign w_wr_en = w_push && (!w_full || w_pop);

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      if (w_pop)   r_rd <= r_rd + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, the head is gated
  always_ff @(posedge clock) begin
    if (!reset && w_wr_en) r_mem[r_wr] <= w_push_data;
  end

  assign ntsc_flag  = !w_empty;
  assign ntsc_pixel = w_empty ? '0 : r_mem[r_rd];
  assign frame_flag = w_frame_flag;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_ntsc_capture.sv
// Bench for ntsc_capture: a per-cycle scoreboard of expected FIFO words,
// a table of hand-computed pixel pairs, and sequences for frame/line corners.
module tb_ntsc_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic        vid_valid;
  logic [29:0] vid_ycrcb;
  logic        vid_field;
  logic        vid_vblank;
  logic        vid_hblank;
  logic        ntsc_flag;
  logic [35:0] ntsc_pixel;
  logic        done_ntsc;
  logic        frame_flag;
  logic        overflow;

  always #5 clock = ~clock;

  ntsc_capture dut (
    .clock      (clock),
    .reset      (reset),
    .vid_valid  (vid_valid),
    .vid_ycrcb  (vid_ycrcb),
    .vid_field  (vid_field),
    .vid_vblank (vid_vblank),
    .vid_hblank (vid_hblank),
    .ntsc_flag  (ntsc_flag),
    .ntsc_pixel (ntsc_pixel),
    .done_ntsc  (done_ntsc),
    .frame_flag (frame_flag),
    .overflow   (overflow)
  );

  typedef struct {
    logic [29:0] a;
    logic [29:0] b;
    logic [35:0] w;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [35:0] q[$];
  bit          ovf_exp = 0;
  bit          ff_exp = 0;
  int          dut_words = 0;

  function automatic logic [17:0] trunc(input logic [29:0] p);
    return {p[29:24], p[19:14], p[9:4]};
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the scoreboard for the edge about to happen, let it
  // happen, then compare every output on the following falling edge.
  task automatic tick(input bit psh, input logic [35:0] w);
    logic [35:0] tmp;
    if (ntsc_flag && done_ntsc) dut_words++;
    if (reset) begin
      q.delete();
      ovf_exp = 0;
    end else begin
      if (done_ntsc && q.size() > 0) tmp = q.pop_front();
      if (psh) begin
        if (q.size() >= 4) ovf_exp = 1;
        else q.push_back(w);
      end
    end
    @(negedge clock);
    chk("ntsc_flag", 36'(ntsc_flag), 36'(q.size() != 0));
    chk("ntsc_pixel", ntsc_pixel, (q.size() != 0) ? q[0] : 36'h0);
    chk("overflow", 36'(overflow), 36'(ovf_exp));
    chk("frame_flag", 36'(frame_flag), 36'(ff_exp));
    ff_exp = 0;
  endtask

  // One hblank-delimited line of random pixels. cap says whether the bench
  // expects this line to be inside the captured window.
  task automatic run_line(input int npix, input bit fld, input bit cap, input bit do_end);
    logic [17:0] half;
    logic [29:0] p;
    bit          hv;
    hv = 0;
    half = '0;
    vid_field  = fld;
    vid_hblank = 1'b0;
    vid_valid  = 1'b0;
    tick(0, 36'h0);
    for (int i = 0; i < npix; i++) begin
      p = 30'($urandom);
      vid_ycrcb = p;
      vid_valid = 1'b1;
      if (!fld && cap && i < 640) begin
        if (hv) begin
          hv = 0;
          tick(1, {half, trunc(p)});
        end else begin
          half = trunc(p);
          hv = 1;
          tick(0, 36'h0);
        end
      end else begin
        tick(0, 36'h0);
      end
    end
    vid_valid = 1'b0;
    if (do_end) begin
      vid_hblank = 1'b1;
      tick(hv, {half, 18'h0});
      tick(0, 36'h0);
    end
  endtask

  // Frame start with an already empty FIFO: pulse two cycles after vblank falls
  task automatic frame_start_quick();
    vid_valid  = 1'b0;
    vid_hblank = 1'b1;
    vid_field  = 1'b0;
    vid_vblank = 1'b1;
    tick(0, 36'h0);
    vid_vblank = 1'b0;
    tick(0, 36'h0);
    ff_exp = 1;
    tick(0, 36'h0);
    tick(0, 36'h0);
  endtask

  task automatic drain();
    done_ntsc = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(0, 36'h0);
  endtask

  initial begin
    vec_t tab[4];
    int   w0;

    tab[0] = '{a: {10'h3FF, 10'h000, 10'h2AA}, b: {10'h000, 10'h3FF, 10'h155}, w: 36'hFC0A80FD5};
    tab[1] = '{a: {10'h000, 10'h000, 10'h000}, b: {10'h3FF, 10'h3FF, 10'h3FF}, w: 36'h00003FFFF};
    tab[2] = '{a: {10'h3FF, 10'h3FF, 10'h3FF}, b: {10'h00F, 10'h00F, 10'h00F}, w: 36'hFFFFC0000};
    tab[3] = '{a: {10'h210, 10'h108, 10'h084}, b: {10'h3F0, 10'h010, 10'h2F0}, w: 36'h85023F06F};

    reset      = 1'b1;
    vid_valid  = 1'b0;
    vid_ycrcb  = '0;
    vid_field  = 1'b0;
    vid_vblank = 1'b0;
    vid_hblank = 1'b1;
    done_ntsc  = 1'b0;
    @(negedge clock);
    repeat (3) tick(0, 36'h0);
    reset = 1'b0;
    tick(0, 36'h0);

    // pixels before any frame start are ignored
    run_line(4, 0, 0, 1);

    frame_start_quick();
    done_ntsc = 1'b1;

    // table of hand-computed packed words, one pair per line
    for (int i = 0; i < 4; i++) begin
      vid_hblank = 1'b0;
      tick(0, 36'h0);
      vid_ycrcb = tab[i].a;
      vid_valid = 1'b1;
      tick(0, 36'h0);
      vid_ycrcb = tab[i].b;
      tick(1, tab[i].w);
      vid_valid  = 1'b0;
      vid_hblank = 1'b1;
      tick(0, 36'h0);
      tick(0, 36'h0);
    end

    // 700-pixel line: only 640 pixels kept
    w0 = dut_words;
    run_line(700, 0, 1, 1);
    chk("words_700", 36'(dut_words - w0), 36'd320);

    // odd pixel count: last word is padded
    run_line(3, 0, 1, 1);
    drain();

    // six words with no consumer: four kept, overflow sticky
    done_ntsc = 1'b0;
    run_line(12, 0, 1, 1);
    drain();

    // frame start with three words queued, one pop every third cycle
    done_ntsc = 1'b0;
    run_line(6, 0, 1, 1);
    vid_vblank = 1'b1;
    tick(0, 36'h0);
    vid_vblank = 1'b0;
    tick(0, 36'h0);
    for (int k = 0; k < 3; k++) begin
      done_ntsc = 1'b0;
      tick(0, 36'h0);
      tick(0, 36'h0);
      done_ntsc = 1'b1;
      tick(0, 36'h0);
    end
    done_ntsc = 1'b0;
    ff_exp = 1;
    tick(0, 36'h0);
    tick(0, 36'h0);
    done_ntsc = 1'b1;
    run_line(2, 0, 1, 1);

    // field 1 lines interleaved; field 0 stops after 240 lines
    frame_start_quick();
    w0 = dut_words;
    for (int l = 0; l < 242; l++) begin
      run_line(2, 1, 0, 1);
      run_line(2, 0, l < 240, 1);
    end
    chk("words_fields", 36'(dut_words - w0), 36'd240);

    // reset mid-line with words queued
    frame_start_quick();
    done_ntsc = 1'b0;
    run_line(4, 0, 1, 0);
    reset = 1'b1;
    tick(0, 36'h0);
    tick(0, 36'h0);
    reset = 1'b0;
    vid_hblank = 1'b1;
    tick(0, 36'h0);
    run_line(4, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
